// File: rtl/strip_occupancy_table_pkg.sv
// Shared types and constants for the strip occupancy table.
//   STRIP_ID_W     strip id width
//   STRIP_WIDTH_W  stored occupied-width width
//   WIDTH_IN_W     width of a single placed item
//   INVALID_WIDTH  width reported for an out-of-range strip (never wins min-select)
//   MAX_STRIPS     largest strip count addressable with STRIP_ID_W bits
package strip_occupancy_table_pkg;

  localparam int unsigned STRIP_ID_W    = 4;
  localparam int unsigned STRIP_WIDTH_W = 8;
  localparam int unsigned WIDTH_IN_W    = 5;
  localparam int unsigned MAX_STRIPS    = 16;

  typedef logic [STRIP_ID_W-1:0]    strip_id_t;
  typedef logic [STRIP_WIDTH_W-1:0] strip_width_t;

  localparam strip_width_t INVALID_WIDTH = 8'hFF;

  function automatic logic id_in_range(input strip_id_t id, input int unsigned num_strips);
    return 32'(id) < num_strips;
  endfunction

endpackage

// File: rtl/strip_occupancy_table_if.sv
// Bus between the strip occupancy table and the min-select/strike pipeline.
//   clear, req_*          lookup side inputs (three candidate strips per request)
//   upd_*                 write-back side inputs from the strike stage
//   out_valid, strip_id_n, occupied_width_n   registered lookup results
//   max_occupied_width    running maximum width (placement height)
// master: the pipeline driving requests/updates; slave: the table.
interface strip_occupancy_table_if;
  import strip_occupancy_table_pkg::*;

  logic         clear;
  logic         req_valid;
  strip_id_t    req_strip_id_1;
  strip_id_t    req_strip_id_2;
  strip_id_t    req_strip_id_3;
  logic         upd_valid;
  strip_id_t    upd_strip_id;
  strip_width_t upd_width;
  logic         upd_strike;

  logic         out_valid;
  strip_id_t    strip_id_1;
  strip_id_t    strip_id_2;
  strip_id_t    strip_id_3;
  strip_width_t occupied_width_1;
  strip_width_t occupied_width_2;
  strip_width_t occupied_width_3;
  strip_width_t max_occupied_width;

  modport master (
    output clear, req_valid, req_strip_id_1, req_strip_id_2, req_strip_id_3,
           upd_valid, upd_strip_id, upd_width, upd_strike,
    input  out_valid, strip_id_1, strip_id_2, strip_id_3,
           occupied_width_1, occupied_width_2, occupied_width_3, max_occupied_width
  );

  modport slave (
    input  clear, req_valid, req_strip_id_1, req_strip_id_2, req_strip_id_3,
           upd_valid, upd_strip_id, upd_width, upd_strike,
    output out_valid, strip_id_1, strip_id_2, strip_id_3,
           occupied_width_1, occupied_width_2, occupied_width_3, max_occupied_width
  );

endinterface

// File: rtl/strip_read_port.sv
// One combinational read port of the strip table.
//   id            strip to look up
//   entries       current table contents
//   we, upd_*     write happening this cycle (forwarded to the read)
//   clear         table being cleared this cycle
//   width         looked-up width; INVALID_WIDTH for an out-of-range id
module strip_read_port
  import strip_occupancy_table_pkg::*;
#(
  parameter int unsigned NUM_STRIPS = MAX_STRIPS
) (
  input  strip_id_t    id,
  input  strip_width_t entries [NUM_STRIPS],
  input  logic         we,
  input  strip_id_t    upd_strip_id,
  input  strip_width_t upd_width,
  input  logic         clear,
  output strip_width_t width
);

  // Priority: range check, then clear, then same-cycle write, then stored entry.
  always_comb begin
    width = INVALID_WIDTH;
    if (id_in_range(id, NUM_STRIPS)) begin
      if (clear)
        width = '0;
      else if (we && (upd_strip_id == id))
        width = upd_width;
      else
        width = entries[id];
    end
  end

endmodule

// File: rtl/strip_occupancy_table.sv
// Per-strip occupied-width store around the min-select/strike pipeline.
//   clk, rst  clock and asynchronous active-high reset
//   bus       strip_occupancy_table_if.slave: three-way lookup with 1-cycle
//             registered results, write-back of the selected strip unless struck,
//             synchronous clear, and the running maximum occupied width.
module strip_occupancy_table
  import strip_occupancy_table_pkg::*;
#(
  parameter int unsigned NUM_STRIPS = MAX_STRIPS
) (
  input logic                    clk,
  input logic                    rst,
  strip_occupancy_table_if.slave bus
);

  strip_width_t entries  [NUM_STRIPS];
  strip_id_t    rd_id    [3];
  strip_width_t rd_width [3];
  logic         we;

  assign rd_id[0] = bus.req_strip_id_1;
  assign rd_id[1] = bus.req_strip_id_2;
  assign rd_id[2] = bus.req_strip_id_3;

  assign we = bus.upd_valid & ~bus.upd_strike & id_in_range(bus.upd_strip_id, NUM_STRIPS);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < NUM_STRIPS; i++)
        entries[i] <= '0;
    end else begin
      for (int unsigned i = 0; i < NUM_STRIPS; i++) begin
        if (bus.clear)
          entries[i] <= '0;
        else if (we && (bus.upd_strip_id == STRIP_ID_W'(i)))
          entries[i] <= bus.upd_width;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      bus.max_occupied_width <= '0;
    else if (bus.clear)
      bus.max_occupied_width <= '0;
    else if (we && (bus.upd_width > bus.max_occupied_width))
      bus.max_occupied_width <= bus.upd_width;
  end

  for (genvar p = 0; p < 3; p++) begin : g_port
    strip_read_port #(
      .NUM_STRIPS(NUM_STRIPS)
    ) u_port (
      .id          (rd_id[p]),
      .entries     (entries),
      .we          (we),
      .upd_strip_id(bus.upd_strip_id),
      .upd_width   (bus.upd_width),
      .clear       (bus.clear),
      .width       (rd_width[p])
    );
  end

  // Results register every cycle regardless of req_valid.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.out_valid        <= 1'b0;
      bus.strip_id_1       <= '0;
      bus.strip_id_2       <= '0;
      bus.strip_id_3       <= '0;
      bus.occupied_width_1 <= '0;
      bus.occupied_width_2 <= '0;
      bus.occupied_width_3 <= '0;
    end else begin
      bus.out_valid        <= bus.req_valid;
      bus.strip_id_1       <= rd_id[0];
      bus.strip_id_2       <= rd_id[1];
      bus.strip_id_3       <= rd_id[2];
      bus.occupied_width_1 <= rd_width[0];
      bus.occupied_width_2 <= rd_width[1];
      bus.occupied_width_3 <= rd_width[2];
    end
  end

endmodule

// File: tb/tb_strip_occupancy_table.sv
// Bench for strip_occupancy_table: two instances (16 and 12 strips) driven with
// identical stimulus, each checked against its own reference table.
module tb_strip_occupancy_table;
  import strip_occupancy_table_pkg::*;

  typedef struct packed {
    logic [3:0] id1, id2, id3;
    logic [7:0] w1, w2, w3, mx;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  strip_occupancy_table_if bus16();
  strip_occupancy_table_if bus12();

  strip_occupancy_table #(.NUM_STRIPS(16)) dut16 (.clk(clk), .rst(rst), .bus(bus16));
  strip_occupancy_table #(.NUM_STRIPS(12)) dut12 (.clk(clk), .rst(rst), .bus(bus12));

  int tests  = 0;
  int errors = 0;

  int           nstr [2] = '{16, 12};
  logic [7:0]   mdl  [2][16];
  logic [7:0]   mx   [2];
  exp_t         q16 [$];
  exp_t         q12 [$];
  exp_t         e16, e12;

  function automatic void check(input string name, input logic [7:0] act, input logic [7:0] exp);
    tests++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endfunction

  function automatic void model_reset();
    for (int k = 0; k < 2; k++) begin
      for (int s = 0; s < 16; s++) mdl[k][s] = 8'h00;
      mx[k] = 8'h00;
    end
  endfunction

  // What a lookup of id sees, given the write/clear landing in the same cycle.
  function automatic logic [7:0] model_read(input int k, input logic [3:0] id, input logic we,
                                           input logic [3:0] uid, input logic [7:0] uw, input logic cl);
    if (int'(id) >= nstr[k]) return 8'hFF;
    if (cl) return 8'h00;
    if (we && uid == id) return uw;
    return mdl[k][id];
  endfunction

  task automatic step(input logic rv, input logic [3:0] a, input logic [3:0] b, input logic [3:0] c,
                      input logic uv, input logic [3:0] uid, input logic [7:0] uw,
                      input logic us, input logic cl);
    exp_t e;
    logic we;
    bus16.req_valid = rv; bus16.req_strip_id_1 = a; bus16.req_strip_id_2 = b; bus16.req_strip_id_3 = c;
    bus16.upd_valid = uv; bus16.upd_strip_id = uid; bus16.upd_width = uw; bus16.upd_strike = us;
    bus16.clear = cl;
    bus12.req_valid = rv; bus12.req_strip_id_1 = a; bus12.req_strip_id_2 = b; bus12.req_strip_id_3 = c;
    bus12.upd_valid = uv; bus12.upd_strip_id = uid; bus12.upd_width = uw; bus12.upd_strike = us;
    bus12.clear = cl;
    for (int k = 0; k < 2; k++) begin
      we = uv && !us && (int'(uid) < nstr[k]);
      e.id1 = a; e.id2 = b; e.id3 = c;
      e.w1 = model_read(k, a, we, uid, uw, cl);
      e.w2 = model_read(k, b, we, uid, uw, cl);
      e.w3 = model_read(k, c, we, uid, uw, cl);
      if (cl) begin
        for (int s = 0; s < 16; s++) mdl[k][s] = 8'h00;
        mx[k] = 8'h00;
      end else if (we) begin
        mdl[k][uid] = uw;
        if (uw > mx[k]) mx[k] = uw;
      end
      e.mx = mx[k];
      if (rv) begin
        if (k == 0) q16.push_back(e);
        else        q12.push_back(e);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    step(1'b0, 4'd0, 4'd0, 4'd0, 1'b0, 4'd0, 8'd0, 1'b0, 1'b0);
  endtask

  always @(negedge clk) begin
    if (!rst && bus16.out_valid) begin
      tests++;
      if (q16.size() == 0) begin
        errors++;
        $display("FAIL d16_unexpected_valid: got out_valid=1 expected no pending request at %0t", $time);
      end else begin
        e16 = q16.pop_front();
        check("d16_id1", 8'(bus16.strip_id_1), 8'(e16.id1));
        check("d16_id2", 8'(bus16.strip_id_2), 8'(e16.id2));
        check("d16_id3", 8'(bus16.strip_id_3), 8'(e16.id3));
        check("d16_w1",  bus16.occupied_width_1, e16.w1);
        check("d16_w2",  bus16.occupied_width_2, e16.w2);
        check("d16_w3",  bus16.occupied_width_3, e16.w3);
        check("d16_max", bus16.max_occupied_width, e16.mx);
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && bus12.out_valid) begin
      tests++;
      if (q12.size() == 0) begin
        errors++;
        $display("FAIL d12_unexpected_valid: got out_valid=1 expected no pending request at %0t", $time);
      end else begin
        e12 = q12.pop_front();
        check("d12_id1", 8'(bus12.strip_id_1), 8'(e12.id1));
        check("d12_id2", 8'(bus12.strip_id_2), 8'(e12.id2));
        check("d12_id3", 8'(bus12.strip_id_3), 8'(e12.id3));
        check("d12_w1",  bus12.occupied_width_1, e12.w1);
        check("d12_w2",  bus12.occupied_width_2, e12.w2);
        check("d12_w3",  bus12.occupied_width_3, e12.w3);
        check("d12_max", bus12.max_occupied_width, e12.mx);
      end
    end
  end

  task automatic check_all_zero(input string tag);
    check({tag, "_d16_valid"}, 8'(bus16.out_valid), 8'h00);
    check({tag, "_d16_id1"},   8'(bus16.strip_id_1), 8'h00);
    check({tag, "_d16_w1"},    bus16.occupied_width_1, 8'h00);
    check({tag, "_d16_w2"},    bus16.occupied_width_2, 8'h00);
    check({tag, "_d16_w3"},    bus16.occupied_width_3, 8'h00);
    check({tag, "_d16_max"},   bus16.max_occupied_width, 8'h00);
    check({tag, "_d12_valid"}, 8'(bus12.out_valid), 8'h00);
    check({tag, "_d12_id3"},   8'(bus12.strip_id_3), 8'h00);
    check({tag, "_d12_w1"},    bus12.occupied_width_1, 8'h00);
    check({tag, "_d12_max"},   bus12.max_occupied_width, 8'h00);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected bench completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    model_reset();
    bus16.req_valid = 1'b0; bus12.req_valid = 1'b0;
    bus16.upd_valid = 1'b0; bus12.upd_valid = 1'b0;
    bus16.clear = 1'b0;     bus12.clear = 1'b0;
    #1;
    check_all_zero("reset");
    #11 rst = 1'b0;
    @(posedge clk); #1;

    // Fresh table reads zero
    step(1'b1, 4'd0, 4'd1, 4'd2, 1'b0, 4'd0, 8'd0, 1'b0, 1'b0);
    // Write then read back, duplicate ids
    step(1'b0, 4'd0, 4'd0, 4'd0, 1'b1, 4'd5, 8'd12, 1'b0, 1'b0);
    step(1'b1, 4'd5, 4'd6, 4'd5, 1'b0, 4'd0, 8'd0, 1'b0, 1'b0);
    // Same-cycle forwarding
    step(1'b1, 4'd3, 4'd3, 4'd7, 1'b1, 4'd3, 8'd20, 1'b0, 1'b0);
    // Struck write is dropped
    step(1'b0, 4'd0, 4'd0, 4'd0, 1'b1, 4'd2, 8'd40, 1'b1, 1'b0);
    step(1'b1, 4'd2, 4'd3, 4'd5, 1'b0, 4'd0, 8'd0, 1'b0, 1'b0);
    // Out-of-range ids on the 12-strip table; write to id 15 ignored there
    step(1'b1, 4'd15, 4'd0, 4'd11, 1'b0, 4'd0, 8'd0, 1'b0, 1'b0);
    step(1'b0, 4'd0, 4'd0, 4'd0, 1'b1, 4'd15, 8'd99, 1'b0, 1'b0);
    step(1'b1, 4'd15, 4'd12, 4'd11, 1'b0, 4'd0, 8'd0, 1'b0, 1'b0);
    // Smaller write must not lower the max
    step(1'b1, 4'd4, 4'd5, 4'd4, 1'b1, 4'd4, 8'd7, 1'b0, 1'b0);
    // Clear beats a simultaneous write; read in clear cycle returns 0
    step(1'b1, 4'd1, 4'd3, 4'd14, 1'b1, 4'd1, 8'd30, 1'b0, 1'b1);
    step(1'b1, 4'd1, 4'd3, 4'd5, 1'b0, 4'd0, 8'd0, 1'b0, 1'b0);

    for (int n = 0; n < 400; n++) begin
      step(1'($urandom_range(0, 3) != 0),
           4'($urandom), 4'($urandom), 4'($urandom),
           1'($urandom_range(0, 1)), 4'($urandom), 8'($urandom),
           1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 31) == 0));
    end

    // Asynchronous reset mid-stream: the in-flight lookup is lost
    step(1'b1, 4'd5, 4'd6, 4'd7, 1'b1, 4'd6, 8'd50, 1'b0, 1'b0);
    step(1'b1, 4'd6, 4'd5, 4'd6, 1'b0, 4'd0, 8'd0, 1'b0, 1'b0);
    rst = 1'b1;
    q16.delete();
    q12.delete();
    model_reset();
    bus16.req_valid = 1'b0; bus12.req_valid = 1'b0;
    bus16.upd_valid = 1'b0; bus12.upd_valid = 1'b0;
    #1;
    check_all_zero("midrst");
    @(posedge clk); #1;
    check_all_zero("midrst_hold");
    rst = 1'b0;
    step(1'b1, 4'd6, 4'd5, 4'd0, 1'b0, 4'd0, 8'd0, 1'b0, 1'b0);
    idle();
    idle();

    tests++;
    if (q16.size() != 0 || q12.size() != 0) begin
      errors++;
      $display("FAIL pending_results: got %0d/%0d unanswered expected 0/0", q16.size(), q12.size());
    end

    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule
